// File: rtl/arith94_pkg.sv
// Shared definitions for the arith94 invariant monitor: FSM encoding,
// property bit positions and default widths.
package arith94_pkg;

  localparam int W_DEF  = 13;
  localparam int CW_DEF = 16;
  localparam int NPROP  = 4;

  localparam int P_MONO  = 0;
  localparam int P_ACC   = 1;
  localparam int P_CONST = 2;
  localparam int P_BOUND = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FAILED = 2'd2
  } state_e;

endpackage

// File: rtl/arith94_prop_eval.sv
// Combinational evaluation of the four loop invariants on the current
// sample against the previous one; only the bound check runs without history.
module arith94_prop_eval
  import arith94_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic             has_prev,
  input  logic [W-1:0]     i_now,
  input  logic [W-1:0]     j_now,
  input  logic [W-1:0]     k_now,
  input  logic [W-1:0]     n_now,
  input  logic [W-1:0]     i_prev,
  input  logic [W-1:0]     j_prev,
  input  logic [W-1:0]     k_prev,
  input  logic [W-1:0]     n_prev,
  output logic [NPROP-1:0] fail_vec
);

  logic [W-1:0] j_delta;
  logic [W:0]   n_plus_one;

  // One extra bit keeps n = 2^W-1 from wrapping the bound to zero.
  assign n_plus_one = {1'b0, n_now} + {{W{1'b0}}, 1'b1};
  assign j_delta    = j_now - j_prev;

  always_comb begin
    fail_vec = '0;
    fail_vec[P_BOUND] = ({1'b0, i_now} > n_plus_one);
    if (has_prev) begin
      fail_vec[P_MONO]  = (i_now < i_prev);
      fail_vec[P_ACC]   = (i_now != i_prev) && (j_delta != i_now);
      fail_vec[P_CONST] = (k_now != k_prev) || (n_now != n_prev);
    end
  end

endmodule

// File: rtl/arith94_invariant_monitor.sv
// Passive checker beside the arith94 loop core: tracks the previous sample,
// records sticky violations and freezes the first failure's index and mask.
module arith94_invariant_monitor
  import arith94_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CW    = CW_DEF,
  parameter int NPROP = arith94_pkg::NPROP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [W-1:0]     i,
  input  logic [W-1:0]     j,
  input  logic [W-1:0]     k,
  input  logic [W-1:0]     n,
  output logic [NPROP-1:0] viol,
  output logic [NPROP-1:0] first_mask,
  output logic [CW-1:0]    first_cycle,
  output logic [CW-1:0]    sample_cnt,
  output logic [1:0]       state,
  output logic [CW-1:0]    pass_run
);

  state_e           state_q, state_d;
  logic [W-1:0]     i_prev_q, i_prev_d, j_prev_q, j_prev_d;
  logic [W-1:0]     k_prev_q, k_prev_d, n_prev_q, n_prev_d;
  logic [NPROP-1:0] viol_q, viol_d, first_mask_q, first_mask_d;
  logic [CW-1:0]    first_cycle_q, first_cycle_d;
  logic [CW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [CW-1:0]    pass_run_q, pass_run_d;
  logic [3:0]       fail_vec;
  logic [CW-1:0]    cnt_inc, run_inc;

  arith94_prop_eval #(.W(W)) u_prop_eval (
    .has_prev (state_q != ST_IDLE),
    .i_now    (i),
    .j_now    (j),
    .k_now    (k),
    .n_now    (n),
    .i_prev   (i_prev_q),
    .j_prev   (j_prev_q),
    .k_prev   (k_prev_q),
    .n_prev   (n_prev_q),
    .fail_vec (fail_vec)
  );

  // Counters hold at all-ones instead of wrapping.
  assign cnt_inc = (sample_cnt_q == '1) ? sample_cnt_q : sample_cnt_q + CW'(1);
  assign run_inc = (pass_run_q == '1) ? pass_run_q : pass_run_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    i_prev_d      = i_prev_q;
    j_prev_d      = j_prev_q;
    k_prev_d      = k_prev_q;
    n_prev_d      = n_prev_q;
    viol_d        = viol_q;
    first_mask_d  = first_mask_q;
    first_cycle_d = first_cycle_q;
    sample_cnt_d  = sample_cnt_q;
    pass_run_d    = pass_run_q;
    if (sample_en) begin
      i_prev_d = i;
      j_prev_d = j;
      k_prev_d = k;
      n_prev_d = n;
      viol_d   = viol_q | fail_vec;
      case (state_q)
        ST_IDLE: begin
          sample_cnt_d = CW'(1);
          if (fail_vec != '0) begin
            first_mask_d  = fail_vec;
            first_cycle_d = sample_cnt_q;
            state_d       = ST_FAILED;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          sample_cnt_d = cnt_inc;
          if (fail_vec != '0) begin
            first_mask_d  = fail_vec;
            first_cycle_d = sample_cnt_q;
            pass_run_d    = '0;
            state_d       = ST_FAILED;
          end else begin
            pass_run_d = run_inc;
          end
        end
        default: begin
          sample_cnt_d = cnt_inc;
          pass_run_d   = (fail_vec != '0) ? '0 : run_inc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      i_prev_q      <= '0;
      j_prev_q      <= '0;
      k_prev_q      <= '0;
      n_prev_q      <= '0;
      viol_q        <= '0;
      first_mask_q  <= '0;
      first_cycle_q <= '0;
      sample_cnt_q  <= '0;
      pass_run_q    <= '0;
    end else begin
      state_q       <= state_d;
      i_prev_q      <= i_prev_d;
      j_prev_q      <= j_prev_d;
      k_prev_q      <= k_prev_d;
      n_prev_q      <= n_prev_d;
      viol_q        <= viol_d;
      first_mask_q  <= first_mask_d;
      first_cycle_q <= first_cycle_d;
      sample_cnt_q  <= sample_cnt_d;
      pass_run_q    <= pass_run_d;
    end
  end

  assign viol        = viol_q;
  assign first_mask  = first_mask_q;
  assign first_cycle = first_cycle_q;
  assign sample_cnt  = sample_cnt_q;
  assign state       = state_q;
  assign pass_run    = pass_run_q;

endmodule
